csr_irq_ctrl: RTL and testbench
===============================

Name: csr_irq_ctrl

Overview:
- Machine-mode interrupt controller that sequences interrupt entry into the CSR file.
- Synchronises the external, timer and software interrupt lines and presents them as mip pending bits.
- Arbitrates among enabled pending interrupts and picks the instant at the writeback stage when the trap is taken.
- Drives the CSR file's interrupt-take strobe and cause code, then flushes the pipeline and redirects fetch to the trap vector.

Parameters:
- SYNC_STAGES, 2, flops in each irq input synchroniser (minimum 2).
- CAUSE_W, 5, width of the cause code field.

Ports:
- clk  input  1  core clock
- cpurst_n  input  1  reset, asynchronous, active-low
- irq_ext  input  1  external interrupt line, asynchronous, level
- irq_timer  input  1  timer interrupt line, asynchronous, level
- irq_soft  input  1  software interrupt line, asynchronous, level
- mstatus_mie  input  1  global machine interrupt enable
- mie_meie / mie_mtie / mie_msie  input  1 each  per-source enables
- mtvec  input  32  trap vector; [1:0]==01 selects vectored mode, otherwise direct
- wb_valid  input  1  writeback stage holds a retiring instruction this cycle
- wb_exp  input  1  writeback instruction raises an exception this cycle
- wb_mret  input  1  writeback instruction is mret
- wb_irqcfg_wr  input  1  writeback CSR write to 0x300 or 0x304 this cycle
- redirect_ack  input  1  fetch accepted the redirect
- mip_meip / mip_mtip / mip_msip  output  1 each  synchronised pending bits
- int_take  output  1  one-cycle strobe to the CSR file (interrupt entry)
- int_causecode  output  CAUSE_W  cause code accompanying int_take
- flush_req  output  1  kill all younger pipeline stages
- redirect_valid  output  1  fetch redirect request
- redirect_pc  output  32  trap target address

Behaviour:
- Reset: asynchronous on cpurst_n low. State goes to IDLE. Synchronisers, mip_*, int_take, int_causecode, flush_req, redirect_valid and redirect_pc all go to 0. Reset asserted mid-operation aborts any sequence immediately.
- Synchronisers: each mip_* equals its irq_* input delayed by SYNC_STAGES cycles. No latching; the level is re-sampled every cycle.
- Eligibility: elig_e = mip_meip & mie_meie; elig_s = mip_msip & mie_msie; elig_t = mip_mtip & mie_mtie. any_elig = mstatus_mie & (elig_e | elig_s | elig_t).
- Priority (fixed): external, cause 11 > software, cause 3 > timer, cause 7.
- FSM states:
  - IDLE: go to REQ when any_elig = 1.
  - REQ: re-evaluate every cycle. If any_elig = 0, return to IDLE with no outputs. If the accept condition holds, go to TAKE.
    - Accept condition: wb_valid & ~wb_exp & ~wb_mret & ~wb_irqcfg_wr.
    - The winning cause is latched into int_causecode on that cycle.
  - TAKE: int_take = 1 for exactly one cycle; flush_req = 1. Go to REDIR.
  - REDIR: flush_req = 1 and redirect_valid = 1, with redirect_pc held stable. Hold until redirect_ack = 1, then go to IDLE and deassert both on the next edge.
- Latency: a request is never taken earlier than 2 cycles after irq assertion plus SYNC_STAGES.
- redirect_pc: base = {mtvec[31:2],2'b00}. Vectored mode gives base + (int_causecode << 2), 32-bit wrap. Direct mode gives base. Computed when leaving REQ.
- Simultaneous events in REQ:
  - wb_exp: the exception has priority and the controller stays in REQ. The CSR file clears MIE, so mstatus_mie drops and the FSM exits to IDLE.
  - wb_mret or wb_irqcfg_wr: the take is deferred by at least one cycle so the updated enables are seen.
- Level rule: an irq deasserted while in TAKE or REDIR does not cancel the sequence; the cause is already committed.
- No new request is evaluated until the FSM returns to IDLE.
- redirect_ack outside REDIR is ignored.
- int_causecode holds its value between takes; it is meaningful only with int_take.

Test Plan:
- Reset with irq_ext=1 and all enables 1 → all outputs 0; after release, mip_meip=1 after 2 cycles, with one int_take and int_causecode=11.
- irq_ext=irq_soft=irq_timer=1, all enabled, mtvec=0x00001001, wb_valid=1 → int_causecode=11, redirect_pc=0x0000102C; after redirect_ack and re-arm, cause 3 is taken, then cause 7.
- mtvec=0x00002000 (direct), irq_timer only → redirect_pc=0x00002000, int_causecode=7, redirect_valid held 5 cycles until redirect_ack, then deasserted next cycle.
- In REQ, wb_exp=1 for the same cycle then mstatus_mie→0 → no int_take; FSM returns to IDLE.
- In REQ, wb_valid=0 for 4 cycles then 1 → int_take fires exactly on the first accept cycle +1.
- cpurst_n pulsed low during REDIR → redirect_valid and flush_req drop asynchronously; with any_elig still 1, a fresh sequence restarts after release.

Source files
------------

// File: rtl/csr_irq_ctrl.sv
// rtl/csr_irq_ctrl.sv - machine-mode interrupt entry sequencer for the CSR file
module csr_irq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CAUSE_W     = 5
) (
  input  logic               clk,
  input  logic               cpurst_n,
  input  logic               irq_ext,
  input  logic               irq_timer,
  input  logic               irq_soft,
  input  logic               mstatus_mie,
  input  logic               mie_meie,
  input  logic               mie_mtie,
  input  logic               mie_msie,
  input  logic [31:0]        mtvec,
  input  logic               wb_valid,
  input  logic               wb_exp,
  input  logic               wb_mret,
  input  logic               wb_irqcfg_wr,
  input  logic               redirect_ack,
  output logic               mip_meip,
  output logic               mip_mtip,
  output logic               mip_msip,
  output logic               int_take,
  output logic [CAUSE_W-1:0] int_causecode,
  output logic               flush_req,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc
);

  typedef enum logic [1:0] {IDLE, REQ, TAKE, REDIR} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_e, sync_t, sync_s;
  logic                   elig_e, elig_s, elig_t, any_elig;
  logic                   accept, commit;
  logic [CAUSE_W-1:0]     win_cause;
  logic [31:0]            base, target;

  // Plain level synchronisers; SYNC_STAGES must be at least 2.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      sync_e <= '0;
      sync_t <= '0;
      sync_s <= '0;
    end else begin
      sync_e <= {sync_e[SYNC_STAGES-2:0], irq_ext};
      sync_t <= {sync_t[SYNC_STAGES-2:0], irq_timer};
      sync_s <= {sync_s[SYNC_STAGES-2:0], irq_soft};
    end
  end

  assign mip_meip = sync_e[SYNC_STAGES-1];
  assign mip_mtip = sync_t[SYNC_STAGES-1];
  assign mip_msip = sync_s[SYNC_STAGES-1];

  assign elig_e   = mip_meip & mie_meie;
  assign elig_s   = mip_msip & mie_msie;
  assign elig_t   = mip_mtip & mie_mtie;
  assign any_elig = mstatus_mie & (elig_e | elig_s | elig_t);

  // mret and mie/mstatus writes change the enables, so the take waits for them to settle.
  assign accept = wb_valid & ~wb_exp & ~wb_mret & ~wb_irqcfg_wr;
  assign commit = (state == REQ) & any_elig & accept;

  always_comb begin
    win_cause = CAUSE_W'(7);
    if (elig_e)      win_cause = CAUSE_W'(11);
    else if (elig_s) win_cause = CAUSE_W'(3);
  end

  assign base   = {mtvec[31:2], 2'b00};
  assign target = (mtvec[1:0] == 2'b01) ? base + (32'(win_cause) << 2) : base;

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state         <= IDLE;
      int_causecode <= '0;
      redirect_pc   <= '0;
    end else begin
      state <= state_nxt;
      if (commit) begin
        int_causecode <= win_cause;
        redirect_pc   <= target;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (any_elig) state_nxt = REQ;
      REQ: begin
        if (!any_elig)   state_nxt = IDLE;
        else if (accept) state_nxt = TAKE;
      end
      TAKE:  state_nxt = REDIR;
      REDIR: if (redirect_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded from state so a reset drops them without waiting for a clock.
  assign int_take       = (state == TAKE);
  assign flush_req      = (state == TAKE) | (state == REDIR);
  assign redirect_valid = (state == REDIR);

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// tb/tb_csr_irq_ctrl.sv - directed self-checking bench for csr_irq_ctrl
module tb_csr_irq_ctrl;

  logic        clk = 1'b0;
  logic        cpurst_n;
  logic        irq_ext, irq_timer, irq_soft;
  logic        mstatus_mie, mie_meie, mie_mtie, mie_msie;
  logic [31:0] mtvec;
  logic        wb_valid, wb_exp, wb_mret, wb_irqcfg_wr, redirect_ack;
  logic        mip_meip, mip_mtip, mip_msip;
  logic        int_take;
  logic [4:0]  int_causecode;
  logic        flush_req, redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_irq_ctrl #(.SYNC_STAGES(2), .CAUSE_W(5)) dut (
    .clk(clk), .cpurst_n(cpurst_n),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .mstatus_mie(mstatus_mie), .mie_meie(mie_meie), .mie_mtie(mie_mtie), .mie_msie(mie_msie),
    .mtvec(mtvec), .wb_valid(wb_valid), .wb_exp(wb_exp), .wb_mret(wb_mret),
    .wb_irqcfg_wr(wb_irqcfg_wr), .redirect_ack(redirect_ack),
    .mip_meip(mip_meip), .mip_mtip(mip_mtip), .mip_msip(mip_msip),
    .int_take(int_take), .int_causecode(int_causecode), .flush_req(flush_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Returns the number of negedges until int_take is seen, or -1 on timeout.
  task automatic wait_take(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (int_take) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic do_ack();
    redirect_ack = 1'b1;
    @(negedge clk);
    redirect_ack = 1'b0;
  endtask

  task automatic quiesce();
    irq_ext = 0; irq_timer = 0; irq_soft = 0;
    wb_valid = 0; wb_exp = 0; wb_mret = 0; wb_irqcfg_wr = 0; redirect_ack = 0;
    repeat (4) @(negedge clk);
    do_ack();
    repeat (2) @(negedge clk);
    mstatus_mie = 1;
  endtask

  task automatic test_reset();
    int n, extra;
    cpurst_n = 0;
    irq_ext = 1; mstatus_mie = 1; mie_meie = 1; mie_mtie = 1; mie_msie = 1; wb_valid = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mip_meip, int_take, flush_req, redirect_valid} !== 4'b0 || redirect_pc !== 32'h0 || int_causecode !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: mip=%b take=%b flush=%b rv=%b pc=%h cause=%0d, required all zero",
               mip_meip, int_take, flush_req, redirect_valid, redirect_pc, int_causecode);
    end
    cpurst_n = 1;
    @(negedge clk);
    checks++;
    if (mip_meip !== 1'b0) begin errors++; $display("FAIL reset_sync1: mip_meip=%b required 0", mip_meip); end
    @(negedge clk);
    checks++;
    if (mip_meip !== 1'b1) begin errors++; $display("FAIL reset_sync2: mip_meip=%b required 1", mip_meip); end
    wait_take(6, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL reset_take_latency: got %0d required 2", n); end
    checks++;
    if (int_causecode !== 5'd11) begin errors++; $display("FAIL reset_cause: got %0d required 11", int_causecode); end
    extra = 0;
    repeat (4) begin @(negedge clk); if (int_take) extra++; end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL reset_single_take: extra takes %0d required 0", extra); end
    quiesce();
  endtask

  task automatic test_priority();
    int n;
    mtvec = 32'h0000_1001; wb_valid = 1;
    irq_ext = 1; irq_soft = 1; irq_timer = 1;
    wait_take(10, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL prio_latency: got %0d required 4", n); end
    checks++;
    if (int_causecode !== 5'd11) begin errors++; $display("FAIL prio_cause_ext: got %0d required 11", int_causecode); end
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_102C) begin
      errors++; $display("FAIL prio_pc_ext: rv=%b pc=%h required 1 0000102c", redirect_valid, redirect_pc);
    end
    irq_ext = 0;
    repeat (3) @(negedge clk);
    do_ack();
    wait_take(6, n);
    checks++;
    if (n < 0 || int_causecode !== 5'd3) begin errors++; $display("FAIL prio_cause_soft: n=%0d cause=%0d required 3", n, int_causecode); end
    @(negedge clk);
    checks++;
    if (redirect_pc !== 32'h0000_100C) begin errors++; $display("FAIL prio_pc_soft: got %h required 0000100c", redirect_pc); end
    irq_soft = 0;
    repeat (3) @(negedge clk);
    do_ack();
    wait_take(6, n);
    checks++;
    if (n < 0 || int_causecode !== 5'd7) begin errors++; $display("FAIL prio_cause_timer: n=%0d cause=%0d required 7", n, int_causecode); end
    @(negedge clk);
    checks++;
    if (redirect_pc !== 32'h0000_101C) begin errors++; $display("FAIL prio_pc_timer: got %h required 0000101c", redirect_pc); end
    quiesce();
  endtask

  task automatic test_direct();
    int n;
    logic held;
    mtvec = 32'h0000_2000; wb_valid = 1; irq_timer = 1;
    wait_take(10, n);
    checks++;
    if (n < 0 || int_causecode !== 5'd7) begin errors++; $display("FAIL direct_cause: n=%0d cause=%0d required 7", n, int_causecode); end
    irq_timer = 0;
    held = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (int_take !== 1'b0) begin errors++; $display("FAIL direct_take_width: int_take=%b required 0", int_take); end
      end
      if (!(redirect_valid === 1'b1 && flush_req === 1'b1 && redirect_pc === 32'h0000_2000)) held = 0;
      if (i == 4) redirect_ack = 1;
    end
    checks++;
    if (held !== 1'b1) begin errors++; $display("FAIL direct_hold: held=%b required 1 (pc=%h)", held, redirect_pc); end
    @(negedge clk);
    redirect_ack = 0;
    checks++;
    if (redirect_valid !== 1'b0 || flush_req !== 1'b0) begin
      errors++; $display("FAIL direct_release: rv=%b flush=%b required 0 0", redirect_valid, flush_req);
    end
    quiesce();
  endtask

  task automatic test_exception();
    int n, takes;
    wb_valid = 0; irq_ext = 1;
    repeat (3) @(negedge clk);
    wb_valid = 1; wb_exp = 1;
    takes = 0;
    @(negedge clk);
    if (int_take) takes++;
    wb_exp = 0; wb_valid = 0; mstatus_mie = 0;
    repeat (5) begin @(negedge clk); if (int_take) takes++; end
    checks++;
    if (takes !== 0) begin errors++; $display("FAIL exc_no_take: takes=%0d required 0", takes); end
    mstatus_mie = 1; wb_valid = 1;
    wait_take(6, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL exc_back_to_idle: take after %0d required 2", n); end
    quiesce();
  endtask

  task automatic test_stall();
    int takes;
    wb_valid = 0; irq_soft = 1;
    repeat (3) @(negedge clk);
    takes = 0;
    redirect_ack = 1;
    repeat (4) begin @(negedge clk); if (int_take) takes++; end
    redirect_ack = 0;
    checks++;
    if (takes !== 0) begin errors++; $display("FAIL stall_no_take: takes=%0d required 0", takes); end
    wb_valid = 1;
    @(negedge clk);
    checks++;
    if (int_take !== 1'b1 || int_causecode !== 5'd3) begin
      errors++; $display("FAIL stall_take: take=%b cause=%0d required 1 3", int_take, int_causecode);
    end
    quiesce();
  endtask

  task automatic test_defer();
    for (int k = 0; k < 2; k++) begin
      wb_valid = 0; irq_ext = 1;
      repeat (3) @(negedge clk);
      wb_valid = 1;
      if (k == 0) wb_mret = 1; else wb_irqcfg_wr = 1;
      @(negedge clk);
      checks++;
      if (int_take !== 1'b0) begin errors++; $display("FAIL defer_block_%0d: int_take=%b required 0", k, int_take); end
      wb_mret = 0; wb_irqcfg_wr = 0;
      @(negedge clk);
      checks++;
      if (int_take !== 1'b1) begin errors++; $display("FAIL defer_take_%0d: int_take=%b required 1", k, int_take); end
      quiesce();
    end
  endtask

  task automatic test_reset_in_redir();
    int n;
    mtvec = 32'h0000_1001; wb_valid = 1; irq_ext = 1;
    wait_take(10, n);
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1) begin errors++; $display("FAIL rst_redir_pre: rv=%b required 1", redirect_valid); end
    #2 cpurst_n = 0;
    #1;
    checks++;
    if (redirect_valid !== 1'b0 || flush_req !== 1'b0 || redirect_pc !== 32'h0) begin
      errors++; $display("FAIL rst_redir_async: rv=%b flush=%b pc=%h required 0 0 0", redirect_valid, flush_req, redirect_pc);
    end
    @(negedge clk);
    cpurst_n = 1;
    wait_take(8, n);
    checks++;
    if (n !== 4 || int_causecode !== 5'd11) begin
      errors++; $display("FAIL rst_redir_restart: n=%0d cause=%0d required 4 11", n, int_causecode);
    end
    quiesce();
  endtask

  initial begin
    cpurst_n = 0;
    irq_ext = 0; irq_timer = 0; irq_soft = 0;
    mstatus_mie = 0; mie_meie = 0; mie_mtie = 0; mie_msie = 0;
    mtvec = 32'h0000_1001;
    wb_valid = 0; wb_exp = 0; wb_mret = 0; wb_irqcfg_wr = 0; redirect_ack = 0;
    test_reset();
    test_priority();
    test_direct();
    test_exception();
    test_stall();
    test_defer();
    test_reset_in_redir();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
